dcache_flush_engine: RTL

Hardware write-back engine for the data cache. It walks every set and way of the cache SRAM and writes each valid+dirty line to off-chip data memory over the existing 256-bit memory handshake, then clears the dirty bit, and optionally the valid bit. It sits between `dcache_sram` and the data-memory port, muxed in front of the cache controller's memory port. It replaces the simulation-only end-of-run flush with a synthesizable, parametrised one.

---
 rtl/dcache_pkg.sv | 33 +++
 rtl/dcache_flush_engine.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/dcache_pkg.sv
// Data-cache geometry, tag-entry layout, flush-engine state encoding and
// write-back address composition shared by the cache controller and flush engine.
package dcache_pkg;

    localparam int unsigned SETS        = 16;
    localparam int unsigned WAYS        = 2;
    localparam int unsigned LINE_BITS   = 256;
    localparam int unsigned ADDR_BITS   = 32;
    localparam int unsigned OFFSET_BITS = 5;
    localparam int unsigned TAG_BITS    = 25;
    localparam int unsigned VALID_BIT   = TAG_BITS - 1;
    localparam int unsigned DIRTY_BIT   = TAG_BITS - 2;

    typedef enum logic [2:0] {
        FS_IDLE = 3'd0,
        FS_RD   = 3'd1,
        FS_CHK  = 3'd2,
        FS_WB   = 3'd3,
        FS_CLR  = 3'd4,
        FS_DONE = 3'd5
    } flush_state_e;

    // Line byte address {tag, set, zero offset}.
    function automatic logic [ADDR_BITS-1:0] compose_addr(
        input logic [ADDR_BITS-1:0] tag_field,
        input logic [ADDR_BITS-1:0] set_idx,
        input int unsigned          set_bits,
        input int unsigned          off_bits
    );
        return (tag_field << (set_bits + off_bits)) | (set_idx << off_bits);
    endfunction

endpackage

// File: rtl/dcache_flush_engine.sv
// Walks every set/way of the data-cache SRAM, writes valid+dirty lines back to
// data memory, then clears dirty (and valid when invalidating).
module dcache_flush_engine #(
    parameter int unsigned SETS        = dcache_pkg::SETS,
    parameter int unsigned WAYS        = dcache_pkg::WAYS,
    parameter int unsigned LINE_BITS   = dcache_pkg::LINE_BITS,
    parameter int unsigned ADDR_BITS   = dcache_pkg::ADDR_BITS,
    parameter int unsigned OFFSET_BITS = dcache_pkg::OFFSET_BITS,
    parameter int unsigned TAG_BITS    = dcache_pkg::TAG_BITS
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          flush_req_i,
    input  logic                          inv_i,
    output logic                          busy_o,
    output logic                          done_o,
    output logic [$clog2(SETS*WAYS):0]    wb_count_o,
    output logic                          sram_rd_o,
    output logic [$clog2(SETS)-1:0]       sram_idx_o,
    output logic [$clog2(WAYS)-1:0]       sram_way_o,
    input  logic [TAG_BITS-1:0]           sram_tag_i,
    input  logic [LINE_BITS-1:0]          sram_data_i,
    output logic                          sram_clr_o,
    output logic                          mem_enable_o,
    output logic                          mem_write_o,
    output logic [ADDR_BITS-1:0]          mem_addr_o,
    output logic [LINE_BITS-1:0]          mem_data_o,
    input  logic                          mem_ack_i
);
    import dcache_pkg::*;

    localparam int unsigned SET_BITS  = $clog2(SETS);
    localparam int unsigned CNT_BITS  = $clog2(SETS * WAYS);
    localparam int unsigned WBC_BITS  = CNT_BITS + 1;
    localparam int unsigned ATAG_BITS = ADDR_BITS - SET_BITS - OFFSET_BITS;

    localparam logic [2:0] IDLE = FS_IDLE;
    localparam logic [2:0] RD   = FS_RD;
    localparam logic [2:0] CHK  = FS_CHK;
    localparam logic [2:0] WB   = FS_WB;
    localparam logic [2:0] CLR  = FS_CLR;
    localparam logic [2:0] DONE = FS_DONE;

    logic [2:0]          state;
    logic [2:0]          state_nxt;
    logic [CNT_BITS-1:0] cnt;
    logic                inv_q;
    logic                start;
    logic                cnt_inc;
    logic                capture;
    logic                wb_done;
    logic                tag_valid;
    logic                tag_dirty;
    logic                last_entry;

    assign tag_valid  = sram_tag_i[TAG_BITS-1];
    assign tag_dirty  = sram_tag_i[TAG_BITS-2];
    assign last_entry = (cnt == {CNT_BITS{1'b1}});

    // Walk counter is {way, set}; set index occupies the low bits.
    assign sram_idx_o = cnt[SET_BITS-1:0];
    assign sram_way_o = cnt[CNT_BITS-1:SET_BITS];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        cnt_inc   = 1'b0;
        capture   = 1'b0;
        wb_done   = 1'b0;
        case (state)
            IDLE: begin
                if (flush_req_i) begin
                    state_nxt = RD;
                    start     = 1'b1;
                end
            end
            RD: state_nxt = CHK;
            CHK: begin
                // A dirty bit on an invalid line is stale and ignored.
                if (tag_valid && tag_dirty) begin
                    state_nxt = WB;
                    capture   = 1'b1;
                end else if (inv_q && tag_valid) begin
                    state_nxt = CLR;
                end else if (last_entry) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = RD;
                    cnt_inc   = 1'b1;
                end
            end
            WB: begin
                if (mem_ack_i) begin
                    state_nxt = CLR;
                    wb_done   = 1'b1;
                end
            end
            CLR: begin
                if (last_entry) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = RD;
                    cnt_inc   = 1'b1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Registered Moore outputs decoded from the next state, plus walk datapath.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt          <= '0;
            inv_q        <= 1'b0;
            wb_count_o   <= '0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            sram_rd_o    <= 1'b0;
            sram_clr_o   <= 1'b0;
            mem_enable_o <= 1'b0;
            mem_write_o  <= 1'b0;
            mem_addr_o   <= '0;
            mem_data_o   <= '0;
        end else begin
            busy_o       <= (state_nxt != IDLE);
            done_o       <= (state_nxt == DONE);
            sram_rd_o    <= (state_nxt == RD);
            sram_clr_o   <= (state_nxt == CLR);
            mem_enable_o <= (state_nxt == WB);
            mem_write_o  <= (state_nxt == WB);
            if (start) begin
                cnt        <= '0;
                wb_count_o <= '0;
                inv_q      <= inv_i;
            end else begin
                if (cnt_inc) begin
                    cnt <= cnt + CNT_BITS'(1);
                end
                if (wb_done) begin
                    wb_count_o <= wb_count_o + WBC_BITS'(1);
                end
            end
            if (capture) begin
                mem_addr_o <= ADDR_BITS'(compose_addr(32'(sram_tag_i[ATAG_BITS-1:0]),
                                                      32'(cnt[SET_BITS-1:0]),
                                                      SET_BITS, OFFSET_BITS));
                mem_data_o <= sram_data_i;
            end
        end
    end

endmodule
